// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding (also used by the APB slave block)
// and default bus widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus APB bus signals of the master bridge.
// master = bridge view, slave = requester/APB-slave environment view.
interface apb_master_bridge_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output P_addr, P_selx, P_enable, P_write, P_wdata,
    input  P_ready, P_slverr, P_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  P_addr, P_selx, P_enable, P_write, P_wdata,
    output P_ready, P_slverr, P_rdata
  );

endinterface

// File: rtl/apb_master_timer.sv
// ACCESS-phase wait counter: cleared on SETUP entry, counts stalled ACCESS
// cycles, flags expiry when the count reaches LAST.
module apb_master_timer #(
  parameter logic [7:0] LAST = 8'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Request-to-APB master bridge: single valid/ready requests through SETUP/ACCESS,
// one-cycle response strobe. Optional ACCESS timeout: APB_MASTER_BRIDGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready=1, bus idle, request captured on req_valid
// SETUP  | P_selx=1, P_enable=0, one cycle
// ACCESS | P_selx=1, P_enable=1, wait for P_ready (or timeout)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  P_clk,
  input logic                  P_rst,
  apb_master_bridge_if.master  bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be 1..255");
  end

  apb_state_t        state, state_nxt;
  logic              capture, done, abort, expired;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_slverr_q;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          capture   = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // a late P_ready still wins over an expiring timer
        if (bus.P_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= done | abort;
      if (capture) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
      end
      if (done) begin
        rsp_slverr_q <= bus.P_slverr;
        if (!write_q) begin
          rsp_rdata_q <= bus.P_rdata;
        end
      end else if (abort) begin
        rsp_slverr_q <= 1'b1;
      end
    end
  end

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic rsp_timeout_q;

  apb_master_timer #(
    .LAST (TIMEOUT_LAST)
  ) u_timer (
    .clk    (P_clk),
    .rst    (P_rst),
    .clear  (capture),
    .inc    ((state == ACCESS) && !bus.P_ready),
    .expire (expired)
  );

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      rsp_timeout_q <= 1'b0;
    end else if (done) begin
      rsp_timeout_q <= 1'b0;
    end else if (abort) begin
      rsp_timeout_q <= 1'b1;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign expired         = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  assign bus.req_ready  = (state == IDLE);
  assign bus.P_selx     = (state != IDLE);
  assign bus.P_enable   = (state == ACCESS);
  assign bus.P_addr     = addr_q;
  assign bus.P_wdata    = wdata_q;
  assign bus.P_write    = write_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (TIMEOUT_CYCLES=4).
// Timeout expectations follow APB_MASTER_BRIDGE_TIMEOUT_EN.
module tb_apb_master_bridge;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .P_clk (clk),
    .P_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer; called at a negedge while the bridge is IDLE.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int waits,
                      input logic [31:0] slv_rdata, input logic slv_err,
                      input logic [31:0] exp_rdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFF0;
    check_eq({tag, " setup selx"}, 64'(bus.P_selx), 64'd1);
    check_eq({tag, " setup enable"}, 64'(bus.P_enable), 64'd0);
    check_eq({tag, " setup addr"}, 64'(bus.P_addr), 64'(addr));
    check_eq({tag, " setup write"}, 64'(bus.P_write), 64'(wr));
    check_eq({tag, " setup req_ready"}, 64'(bus.req_ready), 64'd0);
    if (wr) check_eq({tag, " setup wdata"}, 64'(bus.P_wdata), 64'(wdata));
    // ready during SETUP must be ignored
    bus.P_ready  = 1'b1;
    bus.P_slverr = 1'b1;
    bus.P_rdata  = 32'hA5A5_A5A5;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      check_eq({tag, " access enable"}, 64'(bus.P_enable), 64'd1);
      check_eq({tag, " access addr"}, 64'(bus.P_addr), 64'(addr));
      check_eq({tag, " access rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      bus.P_ready  = (k == waits);
      bus.P_slverr = (k == waits) ? slv_err : 1'b1;
      bus.P_rdata  = (k == waits) ? slv_rdata : (32'hBAD0_0000 | 32'(k));
    end
    @(negedge clk);
    bus.P_ready  = 1'b0;
    bus.P_slverr = 1'b0;
    check_eq({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_eq({tag, " rsp_slverr"}, 64'(bus.rsp_slverr), 64'(slv_err));
    check_eq({tag, " rsp_timeout"}, 64'(bus.rsp_timeout), 64'd0);
    check_eq({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
    check_eq({tag, " idle req_ready"}, 64'(bus.req_ready), 64'd1);
    check_eq({tag, " idle selx"}, 64'(bus.P_selx), 64'd0);
    check_eq({tag, " idle addr held"}, 64'(bus.P_addr), 64'(addr));
  endtask

  logic       exp_sel [0:6];
  logic       exp_rdy [0:6];
  logic [7:0] exp_adr [0:6];
  logic       saw_rsp;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.P_ready   = 1'b0;
    bus.P_slverr  = 1'b0;
    bus.P_rdata   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("reset req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("reset selx", 64'(bus.P_selx), 64'd0);
    check_eq("reset enable", 64'(bus.P_enable), 64'd0);
    check_eq("reset write", 64'(bus.P_write), 64'd0);
    check_eq("reset addr", 64'(bus.P_addr), 64'd0);
    check_eq("reset wdata", 64'(bus.P_wdata), 64'd0);
    check_eq("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("reset rsp_slverr", 64'(bus.rsp_slverr), 64'd0);
    check_eq("reset rsp_timeout", 64'(bus.rsp_timeout), 64'd0);

    xfer("wr0", 1'b1, 32'h04, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("wr0 rsp pulse one cycle", 64'(bus.rsp_valid), 64'd0);
    xfer("rd_err", 1'b0, 32'h1F, 32'h0, 0, 32'h0, 1'b1, 32'h0);
    xfer("rd_w2", 1'b0, 32'h04, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    xfer("wr_keep", 1'b1, 32'h08, 32'h0123_4567, 1, 32'h7777_7777, 1'b0, 32'hDEAD_BEEF);

    // back-to-back writes with req_valid held; slave always ready
    exp_sel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_adr = '{8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20};
    bus.P_ready   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'hCAFE_0001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_eq($sformatf("b2b selx c%0d", c), 64'(bus.P_selx), 64'(exp_sel[c]));
      check_eq($sformatf("b2b req_ready c%0d", c), 64'(bus.req_ready), 64'(exp_rdy[c]));
      check_eq($sformatf("b2b addr c%0d", c), 64'(bus.P_addr), 64'(exp_adr[c]));
      if (c == 0) begin
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFE_0002;
      end
      if (c == 3) bus.req_valid = 1'b0;
    end
    bus.P_ready = 1'b0;

    // stalled read: timeout abort or indefinite wait
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h30;
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("to access%0d enable", k), 64'(bus.P_enable), 64'd1);
      check_eq($sformatf("to access%0d rsp_valid", k), 64'(bus.rsp_valid), 64'd0);
    end
    @(negedge clk);
    check_eq("to rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("to rsp_slverr", 64'(bus.rsp_slverr), 64'd1);
    check_eq("to rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
    check_eq("to rsp_rdata kept", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    check_eq("to idle selx", 64'(bus.P_selx), 64'd0);
    xfer("after_to", 1'b0, 32'h34, 32'h0, 0, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA);
`else
    saw_rsp = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check_eq("hang enable", 64'(bus.P_enable), 64'd1);
    check_eq("hang no rsp", 64'(saw_rsp), 64'd0);
    check_eq("hang addr", 64'(bus.P_addr), 64'h30);
    bus.P_ready = 1'b1;
    bus.P_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.P_ready = 1'b0;
    check_eq("hang release rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("hang release rdata", 64'(bus.rsp_rdata), 64'h0BAD_F00D);
    check_eq("hang release timeout", 64'(bus.rsp_timeout), 64'd0);
`endif

    // reset in the middle of ACCESS
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h40;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mid in access", 64'(bus.P_enable), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid selx", 64'(bus.P_selx), 64'd0);
    check_eq("rst_mid enable", 64'(bus.P_enable), 64'd0);
    check_eq("rst_mid req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("rst_mid rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;
    bus.P_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_mid no late rsp", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_mid still idle", 64'(bus.P_selx), 64'd0);
    check_eq("rst_mid rdata cleared", 64'(bus.rsp_rdata), 64'd0);
    bus.P_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Request-to-APB master bridge that drives the APB slave bus. It accepts single read/write requests on a valid/ready interface and sequences them through the APB SETUP and ACCESS phases. It waits for the slave's `P_ready`, then returns read data and error status on a one-cycle response strobe. It sits directly upstream of the APB slave memory block and feeds its `P_addr`/`P_selx`/`P_enable`/`P_write`/`P_wdata` inputs.

## Interface
Parameters:
- `ADDR_W`, 32: width of `req_addr` and `P_addr`.
- `DATA_W`, 32: width of the write and read data paths.
- `TIMEOUT_CYCLES`, 16: maximum number of ACCESS cycles before abort. Used only when the timeout feature is compiled in; legal range 1..255.

Ports:
- `P_clk`  in  1: clock; all logic is on the rising edge.
- `P_rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: bridge can accept a request.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: transfer address.
- `req_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: one-cycle pulse; transfer complete.
- `rsp_rdata`  out  DATA_W: read data; valid with `rsp_valid` on reads.
- `rsp_slverr`  out  1: error status; valid with `rsp_valid`.
- `rsp_timeout`  out  1: transfer aborted by timeout; valid with `rsp_valid`.
- `P_addr`  out  ADDR_W: APB address.
- `P_selx`  out  1: APB select.
- `P_enable`  out  1: APB enable.
- `P_write`  out  1: APB direction.
- `P_wdata`  out  DATA_W: APB write data.
- `P_ready`  in  1: slave ready.
- `P_slverr`  in  1: slave error.
- `P_rdata`  in  DATA_W: slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Encoding is 2 bits: IDLE=00, SETUP=01, ACCESS=10.
- IDLE:
  - `req_ready`=1; `P_selx`=0, `P_enable`=0.
  - On `req_valid`: register `req_write`/`req_addr`/`req_wdata` into the `P_write`/`P_addr`/`P_wdata` registers, then go to SETUP.
- SETUP: `P_selx`=1, `P_enable`=0; unconditionally go to ACCESS.
- ACCESS: `P_selx`=1, `P_enable`=1.
  - If `P_ready`=1: capture `P_rdata` into `rsp_rdata` (reads only; writes leave `rsp_rdata` unchanged) and `P_slverr` into `rsp_slverr`. Pulse `rsp_valid` and go to IDLE.
  - If `P_ready`=0: stay in ACCESS.
- `req_ready` = (state == IDLE). It is a registered-state decode, with no combinational path from `P_ready`.
- `P_addr`, `P_write` and `P_wdata` hold stable from SETUP through the last ACCESS cycle. They also keep their last values in IDLE; they are never driven to X.
- `P_slverr` and `P_rdata` are ignored whenever the bus is not in ACCESS with `P_ready`=1.
- No response backpressure: `rsp_valid` is a fire-and-forget pulse. `rsp_rdata`, `rsp_slverr` and `rsp_timeout` hold until the next response.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Reset: state=IDLE; `P_selx`, `P_enable`, `P_write`, `rsp_valid`, `rsp_slverr` and `rsp_timeout` are 0; `P_addr`, `P_wdata` and `rsp_rdata` are 0. `req_ready`=1 in the first cycle after reset.
- Request handshake completes at edge T, so SETUP is visible in cycle T+1 and ACCESS from T+2.
- With zero slave wait states, `P_ready` is sampled at edge T+3. `rsp_valid` is high in cycle T+3, and IDLE is reached in the same cycle.
- Each slave wait state adds one ACCESS cycle.
- Minimum request-to-request spacing is 3 cycles: SETUP, ACCESS, IDLE.
- Reset asserted mid-transfer: the next edge forces IDLE and drops `P_selx`/`P_enable`. No `rsp_valid` is issued for the killed transfer.
- `P_ready` asserted during SETUP has no effect.

## Configuration
- Macro: `APB_MASTER_BRIDGE_TIMEOUT_EN`.
- Defined:
  - An ACCESS-cycle counter clears on entry to SETUP and increments each ACCESS cycle with `P_ready`=0.
  - When the counter equals `TIMEOUT_CYCLES-1` and `P_ready`=0, the transfer aborts: go to IDLE and pulse `rsp_valid` with `rsp_slverr`=1 and `rsp_timeout`=1. `rsp_rdata` is unchanged.
  - `P_ready`=1 on that same cycle wins: normal completion, `rsp_timeout`=0.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - `rsp_timeout` is tied to 0; the port remains present.

## Structure
- Shared package `apb_pkg`:
  - state encoding constants IDLE/SETUP/ACCESS, shared with the slave block;
  - default `ADDR_W`/`DATA_W` localparams.
- One natural sub-module: `apb_master_timer`, the load/increment/expire counter. It is instantiated only under `APB_MASTER_BRIDGE_TIMEOUT_EN`.

## Test plan
- Write, no wait: `req_write`=1, `req_addr`=0x04, `req_wdata`=0xDEADBEEF, slave `P_ready`=1 in ACCS.
  - Expect SETUP at T+1 (`P_selx`=1, `P_enable`=0, `P_addr`=0x04) and ACCESS at T+2.
  - Expect `rsp_valid`=1 with `rsp_slverr`=0 at T+3.
- Read with 2 wait states: `req_addr`=0x04, slave returns `P_rdata`=0xDEADBEEF on the third ACCESS cycle.
  - Expect `rsp_rdata`=0xDEADBEEF with `rsp_valid` at T+5.
  - Expect `P_addr` stable throughout.
- Slave error: `P_ready`=1, `P_slverr`=1 on a read of 0x1F.
  - Expect `rsp_slverr`=1 and `rsp_rdata`=0x00000000 (unchanged from reset).
- Back-to-back: `req_valid` held high for 2 requests.
  - Expect the second handshake only in IDLE.
  - Expect `P_selx` low for exactly 1 cycle between transfers.
- Reset mid-ACCESS: assert `P_rst` with `P_ready`=0.
  - Expect `P_selx`=`P_enable`=0 after the next edge, no `rsp_valid`, and `req_ready`=1.
- Timeout (macro defined, `TIMEOUT_CYCLES`=4): hold `P_ready`=0.
  - Expect `rsp_valid`, `rsp_slverr` and `rsp_timeout` all =1 after 4 ACCESS cycles, then IDLE.
  - Macro undefined: the bridge still sits in ACCESS after 100 cycles.
